// File: rtl/md_sched.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs mult/div as
// fixed-latency operations and raises the stall that holds MD instructions in D.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        md_use_D,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic        wr_p_q, wr_p_d;

  logic [63:0] sprod_s, uprod_s;
  logic [31:0] div_b_s, squot_s, srem_s, uquot_s, urem_s;
  logic        div_zero_s, div_ovf_s;

  // Datapath: products and guarded quotients for the current E-stage operands
  always_comb begin
    sprod_s    = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
    uprod_s    = {32'd0, A_E} * {32'd0, B_E};
    div_zero_s = (B_E == 32'd0);
    div_ovf_s  = (A_E == 32'h8000_0000) && (B_E == 32'hFFFF_FFFF);
    // Substitute a harmless divisor so the dividers never see 0 or the -2^31/-1 overflow
    if (div_zero_s || div_ovf_s) begin
      div_b_s = 32'd1;
    end else begin
      div_b_s = B_E;
    end
    squot_s = $signed(A_E) / $signed(div_b_s);
    srem_s  = $signed(A_E) % $signed(div_b_s);
    uquot_s = A_E / div_b_s;
    urem_s  = A_E % div_b_s;
  end

  // Next-state, pending results and HI/LO updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    wr_p_d  = wr_p_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        case (MDUOp_E)
          OP_MULT: begin
            start   = 1'b1;
            hi_p_d  = sprod_s[63:32];
            lo_p_d  = sprod_s[31:0];
            wr_p_d  = 1'b1;
            count_d = MULT_N;
            state_d = BUSY;
          end
          OP_MULTU: begin
            start   = 1'b1;
            hi_p_d  = uprod_s[63:32];
            lo_p_d  = uprod_s[31:0];
            wr_p_d  = 1'b1;
            count_d = MULT_N;
            state_d = BUSY;
          end
          OP_DIV: begin
            start   = 1'b1;
            if (div_ovf_s) begin
              hi_p_d = 32'd0;
              lo_p_d = 32'h8000_0000;
            end else begin
              hi_p_d = srem_s;
              lo_p_d = squot_s;
            end
            wr_p_d  = !div_zero_s;
            count_d = DIV_N;
            state_d = BUSY;
          end
          OP_DIVU: begin
            start   = 1'b1;
            hi_p_d  = urem_s;
            lo_p_d  = uquot_s;
            wr_p_d  = !div_zero_s;
            count_d = DIV_N;
            state_d = BUSY;
          end
          OP_MTHI: hi_d = A_E;
          OP_MTLO: lo_d = A_E;
          default: ;
        endcase
      end
      BUSY: begin
        if (count_q == 4'd1) begin
          count_d = 4'd0;
          state_d = IDLE;
          if (wr_p_q) begin
            hi_d = hi_p_q;
            lo_d = lo_p_q;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
      wr_p_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      wr_p_q  <= wr_p_d;
    end
  end

  // Output read mux and stall
  always_comb begin
    busy     = (state_q == BUSY);
    stall_md = md_use_D & (start | busy);
    HI       = hi_q;
    LO       = lo_q;
    case (MDUOp_E)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed, table-driven self-checking bench for md_sched.
module tb_md_sched;

  logic        clk, reset;
  logic [3:0]  MDUOp_E;
  logic [31:0] A_E, B_E;
  logic        md_use_D;
  logic        start, busy, stall_md;
  logic [31:0] HI, LO, MDUOut;

  int errors = 0;
  int checks = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp_E(MDUOp_E), .A_E(A_E), .B_E(B_E),
    .md_use_D(md_use_D), .start(start), .busy(busy), .stall_md(stall_md),
    .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol check: the pipeline must never present an MD op while busy
  always @(posedge clk) begin
    if (!reset && busy && MDUOp_E >= 4'd1 && MDUOp_E <= 4'd8) begin
      errors++;
      $display("FAIL md_op_while_busy: op=%0d presented while busy", MDUOp_E);
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div op for one cycle, then count busy cycles (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    MDUOp_E = op; A_E = a; B_E = b;
    #1;
    chk("start_on_issue", {31'd0, start}, 32'd1);
    chk("idle_before_issue", {31'd0, busy}, 32'd0);
    tick();
    MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
    #1;
    chk("start_drops", {31'd0, start}, 32'd0);
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  task automatic mv_to(input logic [3:0] op, input logic [31:0] a);
    MDUOp_E = op; A_E = a;
    tick();
    MDUOp_E = 4'd0; A_E = 32'd0;
  endtask

  task automatic read_md(input logic [3:0] op, input string name, input logic [31:0] exp);
    MDUOp_E = op;
    #1;
    chk(name, MDUOut, exp);
    MDUOp_E = 4'd0;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{4'd4, 32'd100,       32'd3,         32'h0000_0001, 32'h0000_0021, 10};
    vecs[5] = '{4'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[6] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

    reset = 1'b1; MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0; md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    read_md(4'd6, "rst_mduout", 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].n));
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      read_md(4'd6, $sformatf("v%0d_mflo", i), vecs[i].lo);
      read_md(4'd5, $sformatf("v%0d_mfhi", i), vecs[i].hi);
      tick();
    end

    // mthi/mtlo preload, then divide by zero leaves HI/LO untouched
    mv_to(4'd7, 32'h11);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    mv_to(4'd8, 32'h22);
    chk("mthi_hi", HI, 32'h11);
    chk("mtlo_lo", LO, 32'h22);
    run_op(4'd4, 32'd7, 32'd0, cyc);
    chk("div0_busy_cycles", 32'(cyc), 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);
    tick();

    // Stall covers the start cycle and every busy cycle
    md_use_D = 1'b1; MDUOp_E = 4'd1; A_E = 32'd3; B_E = 32'd4;
    #1;
    chk("stall_start_cycle", {31'd0, stall_md}, 32'd1);
    tick();
    MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_busy%0d", k), {31'd0, stall_md}, 32'd1);
      chk($sformatf("busy_hold%0d", k), {31'd0, busy}, 32'd1);
      tick();
    end
    #1;
    chk("stall_after", {31'd0, stall_md}, 32'd0);
    chk("stall_lo", LO, 32'd12);
    md_use_D = 1'b0;
    MDUOp_E = 4'd1; A_E = 32'd2; B_E = 32'd2;
    tick();
    MDUOp_E = 4'd0;
    #1;
    chk("no_stall_non_md", {31'd0, stall_md}, 32'd0);
    chk("busy_non_md", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      tick();
    end
    chk("lo_2x2", LO, 32'd4);

    // Reset in the 3rd busy cycle of div 100/3 clears everything at once
    mv_to(4'd7, 32'h55);
    MDUOp_E = 4'd3; A_E = 32'd100; B_E = 32'd3;
    tick();
    MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
    tick();
    tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_hi", HI, 32'h55);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
